// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
// SCAN_GHOST_BLANK_EN inserts a blank phase after every digit.
package display_pkg;

    localparam int unsigned NumDigits = 4;

`ifdef SCAN_GHOST_BLANK_EN
    localparam int unsigned NumPhases = 8;
`else
    localparam int unsigned NumPhases = 4;
`endif

    localparam int unsigned PhaseW = $clog2(NumPhases);

    localparam logic [6:0] SegDash = 7'h40;

    // Entry k is the pattern for decimal digit k (bit0 = a .. bit6 = g).
    localparam logic [9:0][6:0] SegTable = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern, with a dash override.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        if (dash_i) begin
            seg_o = SegDash;
        end else if (bcd_i <= 4'd9) begin
            seg_o = SegTable[bcd_i];
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for a 4-digit HH:MM display with frame snapshotting.
// Define SCAN_GHOST_BLANK_EN for 8 phases with a blank phase after each digit.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] data_show,
    output logic [2:0]  byte_status,
    output logic [3:0]  bytee,
    output logic [6:0]  segment,
    output logic        frame_done
);

    localparam logic [15:0]       DivLast   = 16'(SCAN_DIV - 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(NumPhases - 1);

    scan_state_e       state_q, state_d;
    logic [15:0]       presc_q, presc_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic [11:0]       snap_q, snap_d;
    logic [2:0]        status_q, status_d;
    logic [3:0]        bytee_q, bytee_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_done_q, frame_done_d;

    logic [1:0] digit_idx;
    logic       digit_lit;
    logic [5:0] field;
    logic [3:0] digit_bcd;
    logic       digit_dash;
    logic [6:0] digit_seg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            phase_q      <= '0;
            snap_q       <= '0;
            status_q     <= '0;
            bytee_q      <= '0;
            seg_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            snap_q       <= snap_d;
            status_q     <= status_d;
            bytee_q      <= bytee_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next scan position; the snapshot is taken on every edge that enters phase 0.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        phase_d      = phase_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            presc_d = '0;
            phase_d = '0;
        end else if (state_q == StIdle) begin
            state_d = StScan;
            presc_d = '0;
            phase_d = '0;
            snap_d  = data_show;
        end else if (presc_q == DivLast) begin
            presc_d = '0;
            if (phase_q == PhaseLast) begin
                phase_d      = '0;
                snap_d       = data_show;
                frame_done_d = 1'b1;
            end else begin
                phase_d = phase_q + PhaseW'(1);
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

`ifdef SCAN_GHOST_BLANK_EN
    assign digit_idx = phase_d[2:1];
    assign digit_lit = ~phase_d[0];
    assign status_d  = phase_d;
`else
    assign digit_idx = phase_d;
    assign digit_lit = 1'b1;
    assign status_d  = {1'b0, phase_d};
`endif

    // Outputs are decoded from the next phase so they change on the phase edge itself.
    always_comb begin
        field      = digit_idx[1] ? snap_d[11:6] : snap_d[5:0];
        digit_dash = (field > 6'd59);
        digit_bcd  = digit_idx[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
    end

    seg7_decode u_seg7_decode (
        .bcd_i  (digit_bcd),
        .dash_i (digit_dash),
        .seg_o  (digit_seg)
    );

    always_comb begin
        bytee_d = 4'b0000;
        seg_d   = 7'h00;
        if (enable && digit_lit) begin
            bytee_d = 4'b0001 << digit_idx;
            seg_d   = digit_seg;
        end
    end

    assign byte_status = status_q;
    assign bytee       = bytee_q;
    assign segment     = seg_q;
    assign frame_done  = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per scan phase; legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  scan run; 0 holds block in idle.
REQ-005 data_show  input  12  [11:6] high field (hours), [5:0] low field (minutes), binary.
REQ-006 byte_status  output  3  current scan phase index.
REQ-007 bytee  output  4  one-hot digit enable, active-high; bit k = digit k.
REQ-008 segment  output  7  segment pattern, active-high, bit0=a .. bit6=g.
REQ-009 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-010 A 16-bit prescaler SHALL count 0..SCAN_DIV-1; its wrap ("tick") SHALL advance the phase by one.
REQ-011 Digit map SHALL be: digit0 = low ones, digit1 = low tens, digit2 = high ones, digit3 = high tens.
REQ-012 BCD split SHALL be value%10 and value/10 per field; any field value >59 SHALL show dash (7'h40) on both of its digits.
REQ-013 Segment codes SHALL be 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-014 data_show SHALL be snapshotted on the edge that enters phase 0; digits within a frame SHALL use only that snapshot (no tearing).
REQ-015 byte_status, bytee and segment SHALL be registered and SHALL update on the same edge as the phase change; no extra latency.
REQ-016 frame_done SHALL be 1 for exactly the cycle after the edge that wraps the last phase to phase 0.
REQ-017 While enable=0: prescaler=0, phase=0, bytee=0, segment=0, frame_done=0, synchronously.
REQ-018 The first edge with enable=1 after idle SHALL load the snapshot and drive phase 0 outputs; each phase then lasts exactly SCAN_DIV cycles.
REQ-019 enable dropping mid-frame SHALL abort the frame without a frame_done pulse.
REQ-020 data_show changes mid-frame SHALL have no effect until the next phase 0.

Reset
REQ-021 reset low SHALL immediately force prescaler=0, phase=0, snapshot=0, byte_status=0, bytee=0, segment=0, frame_done=0.
REQ-022 After reset release, behaviour SHALL equal the idle-to-enable behaviour of REQ-018.

Configuration
REQ-023 Macro SCAN_GHOST_BLANK_EN defined: 8 phases 0..7; even phase p lights digit p/2; odd phases are blank (bytee=0, segment=0); frame = 8*SCAN_DIV cycles.
REQ-024 Macro undefined: 4 phases 0..3; phase p lights digit p; byte_status = {1'b0, phase[1:0]}; frame = 4*SCAN_DIV cycles.

Structure
REQ-025 Shared package display_pkg SHALL hold the segment code table, the dash constant, digit-count and phase-count constants.
REQ-026 One sub-module seg7_decode (4-bit BCD plus dash flag to 7-bit pattern) SHALL be instantiated once.

Verification
REQ-027 SCAN_DIV=4, blank off, data_show=12'h322 (12:34) -> phases 0..3 show bytee 1,2,4,8 with segment 66,4F,5B,06, each held 4 cycles.
REQ-028 Same stimulus, SCAN_GHOST_BLANK_EN defined -> byte_status 0..7; odd phases bytee=0, segment=0; frame_done every 32 cycles.
REQ-029 data_show changed from 12:34 to 05:07 in phase 2 -> phases 2,3 still show 2,1; next frame shows 7,0,5,0.
REQ-030 data_show low field=60 -> digits 0,1 show 40; high field unaffected.
REQ-031 reset asserted mid-phase 2 -> all outputs 0 without a clock edge; after release with enable=1, phase 0 outputs on first edge.
REQ-032 enable dropped in phase 3 -> outputs 0 on next edge, no frame_done; re-enable restarts at phase 0.
